// File: rtl/exec_sequencer.sv
// exec_sequencer: walks the PC over instruction memory, issues one ALU op per word, reports busy/done/error.
// Optional single-step mode is compiled in with `define SINGLE_STEP_EN.
module exec_sequencer #(
  parameter int NUM_INSTR   = 10,
  parameter int MAX_STEPS   = 255,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        executeButton,
  input  logic [3:0]  instructionsSet,
  output logic [3:0]  instr_addr,
  input  logic [17:0] instr_rdata,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_rd,
  output logic [2:0]  alu_rs,
  output logic [7:0]  alu_imm,
  input  logic        alu_done,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  pc,
  output logic [3:0]  state_dbg
);

  // ALU handshake: alu_start is a one-cycle request with alu_op/rd/rs/imm valid and held until the
  // next request; alu_done is a one-cycle completion that is only honoured while in WAIT.
  localparam int         TW          = $clog2(ALU_TIMEOUT + 1);
  localparam logic [3:0] NUM_INSTR_L = 4'(NUM_INSTR);
  localparam logic [7:0] MAX_STEPS_L = 8'(MAX_STEPS);
  localparam logic [TW-1:0] TMO_L    = TW'(ALU_TIMEOUT);

`ifdef SINGLE_STEP_EN
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_ISSUE = 4'd3, S_WAIT = 4'd4,
    S_NEXT = 4'd5, S_DONE = 4'd6, S_ERR = 4'd7, S_STEP_HOLD = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_ISSUE = 4'd3, S_WAIT = 4'd4,
    S_NEXT = 4'd5, S_DONE = 4'd6, S_ERR = 4'd7
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [3:0]    pc_q, pc_d, addr_q, addr_d, op_q, op_d;
  logic [2:0]    rd_q, rd_d, rs_q, rs_d;
  logic [7:0]    imm_q, imm_d, steps_q, steps_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
  logic          go;
  logic [3:0]    n_eff;

  assign n_eff = (instructionsSet > NUM_INSTR_L) ? NUM_INSTR_L : instructionsSet;
  // Button is active-low: a falling edge of the synchronised level is one press.
  assign go    = btn_prev_q & ~btn_s2_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    steps_d    = steps_q;
    tmo_d      = tmo_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    btn_s1_d   = executeButton;
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          pc_d    = 4'd0;
          steps_d = 8'd0;
          error_d = 1'b0;
          if (n_eff == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        addr_d  = pc_q;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (instr_rdata[17:14] == 4'hF) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (instr_rdata[17:14] == 4'hE) begin
          pc_d    = instr_rdata[3:0];
          state_d = S_NEXT;
        end else begin
          // The operand registers double as the instruction register for ALU ops.
          op_d    = instr_rdata[17:14];
          rd_d    = instr_rdata[13:11];
          rs_d    = instr_rdata[10:8];
          imm_d   = instr_rdata[7:0];
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TW'(1);  // the ISSUE cycle is the first elapsed cycle after alu_start
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          pc_d    = pc_q + 4'd1;
          state_d = S_NEXT;
        end else if (tmo_q + TW'(1) == TMO_L) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_NEXT: begin
        steps_d = steps_q + 8'd1;
        if (steps_d == MAX_STEPS_L) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else if (pc_q >= n_eff) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
`ifdef SINGLE_STEP_EN
          state_d = S_STEP_HOLD;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef SINGLE_STEP_EN
      S_STEP_HOLD: begin
        if (go) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 4'd0;
      addr_q     <= 4'd0;
      op_q       <= 4'd0;
      rd_q       <= 3'd0;
      rs_q       <= 3'd0;
      imm_q      <= 8'd0;
      steps_q    <= 8'd0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      btn_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
      steps_q    <= steps_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign instr_addr = addr_q;
  assign alu_start  = start_q;
  assign alu_op     = op_q;
  assign alu_rd     = rd_q;
  assign alu_rs     = rs_q;
  assign alu_imm    = imm_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign pc         = pc_q;
  assign state_dbg  = state_q;

endmodule
